// File: rtl/knight_move_gen.sv
// Knight move generator.
// Loads a 64-square board over the Avalon-MM master, locates the knight
// matching PIECE, and writes one full board image per legal knight move
// into the destination buffer. Register 0 reads stall until done.
module knight_move_gen (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIND,
        S_CAND,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t      state;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic [7:0]  piece;
    logic [3:0]  count;
    logic        done;

    logic [7:0]  board [0:63];
    logic [5:0]  idx;
    logic        rd_pending;
    logic [5:0]  origin;
    logic [5:0]  target;
    logic [2:0]  cand;

    logic [4:0]  drow;
    logic [4:0]  dcol;
    logic [4:0]  trow;
    logic [4:0]  tcol;
    logic [5:0]  t_idx;
    logic [7:0]  t_code;
    logic        cand_legal;

    logic [5:0]  pix_j;
    logic [5:0]  pix_t;
    logic [7:0]  pix;
    logic        board_we;

    logic        unused_rdata;
    assign unused_rdata = ^master_readdata[31:8];

    // Slave stall: busy, or a COUNT read before generation has completed
    always_comb begin
        slave_waitrequest = (state != S_IDLE) ||
                            (slave_read && (slave_address == 4'd0) && !done);
    end

    // Slave register read mux
    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                4'd0:    slave_readdata = {28'd0, count};
                4'd1:    slave_readdata = src_base;
                4'd2:    slave_readdata = {24'd0, piece};
                4'd3:    slave_readdata = dst_base;
                default: slave_readdata = '0;
            endcase
        end
    end

    // Current candidate target square and its legality.
    // Row/col are 5-bit two's complement; off-board values (-2..-1, 8..9)
    // always have bit 4 or bit 3 set, which is the bounds test.
    always_comb begin
        drow = '0;
        dcol = '0;
        case (cand)
            3'd0: begin drow = 5'd2;  dcol = 5'd1;  end
            3'd1: begin drow = 5'd2;  dcol = 5'h1F; end
            3'd2: begin drow = 5'h1E; dcol = 5'd1;  end
            3'd3: begin drow = 5'h1E; dcol = 5'h1F; end
            3'd4: begin drow = 5'd1;  dcol = 5'd2;  end
            3'd5: begin drow = 5'd1;  dcol = 5'h1E; end
            3'd6: begin drow = 5'h1F; dcol = 5'd2;  end
            default: begin drow = 5'h1F; dcol = 5'h1E; end
        endcase
        trow       = {2'b00, origin[5:3]} + drow;
        tcol       = {2'b00, origin[2:0]} + dcol;
        t_idx      = {trow[2:0], tcol[2:0]};
        t_code     = board[t_idx];
        cand_legal = (trow[4:3] == 2'b00) && (tcol[4:3] == 2'b00) &&
                     ((t_code == 8'h00) || (t_code[7] != piece[7]));
    end

    // Output board byte for the next write: square 0 when a move starts,
    // otherwise the square after the one currently being written
    always_comb begin
        pix_j = (state == S_CAND) ? 6'd0 : 6'(idx + 6'd1);
        pix_t = (state == S_CAND) ? t_idx : target;
        if (pix_j == origin)
            pix = 8'h00;
        else if (pix_j == pix_t)
            pix = piece;
        else
            pix = board[pix_j];
    end

    assign board_we = (state == S_LOAD) && rd_pending && master_readdatavalid;

    // Capture each returned square into the internal board copy
    always_ff @(posedge clk) begin
        if (board_we)
            board[idx] <= master_readdata[7:0];
    end

    // Control FSM with registered master outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            src_base         <= '0;
            dst_base         <= '0;
            piece            <= '0;
            count            <= '0;
            done             <= 1'b1;
            idx              <= '0;
            rd_pending       <= 1'b0;
            origin           <= '0;
            target           <= '0;
            cand             <= '0;
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (slave_write && !slave_waitrequest) begin
                        case (slave_address)
                            4'd0: begin
                                state          <= S_LOAD;
                                done           <= 1'b0;
                                count          <= '0;
                                idx            <= '0;
                                rd_pending     <= 1'b0;
                                master_read    <= 1'b1;
                                master_address <= src_base;
                            end
                            4'd1:    src_base <= slave_writedata;
                            4'd2:    piece    <= slave_writedata[7:0];
                            4'd3:    dst_base <= slave_writedata;
                            default: ;
                        endcase
                    end
                end

                S_LOAD: begin
                    if (master_read && !master_waitrequest) begin
                        master_read <= 1'b0;
                        rd_pending  <= 1'b1;
                    end else if (rd_pending && master_readdatavalid) begin
                        rd_pending <= 1'b0;
                        if (idx == 6'd63) begin
                            idx   <= '0;
                            state <= S_FIND;
                        end else begin
                            idx            <= idx + 6'd1;
                            master_read    <= 1'b1;
                            master_address <= src_base + 32'(idx) + 32'd1;
                        end
                    end
                end

                S_FIND: begin
                    if (board[idx] == piece) begin
                        origin <= idx;
                        cand   <= '0;
                        state  <= S_CAND;
                    end else if (idx == 6'd63) begin
                        state <= S_FINISH;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end

                S_CAND: begin
                    if (cand_legal) begin
                        target           <= t_idx;
                        idx              <= '0;
                        master_write     <= 1'b1;
                        master_address   <= dst_base + {22'd0, count, 6'd0};
                        master_writedata <= {{24{pix[7]}}, pix};
                        state            <= S_EMIT;
                    end else if (cand == 3'd7) begin
                        state <= S_FINISH;
                    end else begin
                        cand <= cand + 3'd1;
                    end
                end

                S_EMIT: begin
                    if (!master_waitrequest) begin
                        if (idx == 6'd63) begin
                            master_write <= 1'b0;
                            count        <= count + 4'd1;
                            if (cand == 3'd7) begin
                                state <= S_FINISH;
                            end else begin
                                cand  <= cand + 3'd1;
                                state <= S_CAND;
                            end
                        end else begin
                            idx              <= idx + 6'd1;
                            master_address   <= master_address + 32'd1;
                            master_writedata <= {{24{pix[7]}}, pix};
                        end
                    end
                end

                S_FINISH: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knight_move_gen.sv
// Self-checking bench for knight_move_gen: byte memory model on the master
// port, a move-list reference model, and a per-cycle bus monitor.
module tb_knight_move_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    always #5 clk = ~clk;

    knight_move_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .slave_waitrequest   (slave_waitrequest),
        .slave_address       (slave_address),
        .slave_read          (slave_read),
        .slave_readdata      (slave_readdata),
        .slave_write         (slave_write),
        .slave_writedata     (slave_writedata),
        .master_waitrequest  (master_waitrequest),
        .master_address      (master_address),
        .master_read         (master_read),
        .master_readdata     (master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_write        (master_write),
        .master_writedata    (master_writedata)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] imem    [0:1023];
    logic [7:0] dmem    [0:1023];
    logic [7:0] exp_mem [0:1023];
    logic [7:0] brd     [64];
    logic       clr = 1'b0;

    int wait_n    = 0;
    int valid_dly = 0;
    int wcnt;
    logic pend;
    int pcnt;
    logic [31:0] paddr;

    int exp_src, exp_dst, exp_count;
    int reads_seen = 0;
    int writes_seen = 0;

    int dr [8] = '{2, 2, -2, -2, 1, 1, -1, -1};
    int dc [8] = '{1, -1, 1, -1, 2, -2, 2, -2};

    assign master_waitrequest = (master_read || master_write) && (wcnt < wait_n);

    // Byte memory with configurable stall and read latency
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt                 <= 0;
            pend                 <= 1'b0;
            pcnt                 <= 0;
            paddr                <= '0;
            master_readdatavalid <= 1'b0;
            master_readdata      <= '0;
        end else begin
            master_readdatavalid <= 1'b0;
            if (clr)
                for (int i = 0; i < 1024; i++) dmem[i] <= imem[i];
            if (pend) begin
                if (pcnt == 0) begin
                    master_readdatavalid <= 1'b1;
                    master_readdata      <= {24'h5A5A5A, dmem[paddr[9:0]]};
                    pend                 <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1;
                end
            end
            if (master_read || master_write) begin
                if (master_waitrequest) begin
                    wcnt <= wcnt + 1;
                end else begin
                    wcnt <= 0;
                    if (master_write) dmem[master_address[9:0]] <= master_writedata[7:0];
                    if (master_read) begin
                        pend  <= 1'b1;
                        pcnt  <= valid_dly;
                        paddr <= master_address;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: find the knight, then walk the eight offsets in order
    function automatic void model(input logic [7:0] pc, output int org,
                                  output int cnt, output int tg[8]);
        int r, c, ts, ps;
        org = -1;
        cnt = 0;
        for (int k = 0; k < 8; k++) tg[k] = -1;
        for (int i = 63; i >= 0; i--)
            if (brd[i] == pc) org = i;
        if (org < 0) return;
        ps = int'($signed(pc));
        for (int k = 0; k < 8; k++) begin
            r = org / 8 + dr[k];
            c = org % 8 + dc[k];
            if (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
                ts = int'($signed(brd[r * 8 + c]));
                if (ts == 0 || ((ts < 0) != (ps < 0))) begin
                    tg[cnt] = r * 8 + c;
                    cnt++;
                end
            end
        end
    endfunction

    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        while (slave_waitrequest && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) begin
            errors++; checks++;
            $display("FAIL slave_wr_timeout: got %0d cycles expected < 20000", n);
        end
        @(posedge clk);
        #1 slave_write = 1'b0;
    endtask

    task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int stall);
        stall = 0;
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        #1;
        while (slave_waitrequest && stall < 20000) begin @(negedge clk); #1; stall++; end
        if (stall >= 20000) begin
            errors++; checks++;
            $display("FAIL slave_rd_timeout: got %0d cycles expected < 20000", stall);
        end
        d = slave_readdata;
        @(posedge clk);
        #1 slave_read = 1'b0;
    endtask

    // Load memory image, build the expected image, program the registers
    task automatic setup(input int src, input int dst, input logic [7:0] pc, output int cnt,
                         output int tg[8]);
        int org;
        for (int i = 0; i < 1024; i++) imem[i] = 8'h77;
        for (int i = 0; i < 64; i++) imem[src + i] = brd[i];
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        model(pc, org, cnt, tg);
        for (int i = 0; i < 1024; i++) exp_mem[i] = imem[i];
        for (int k = 0; k < cnt; k++)
            for (int j = 0; j < 64; j++)
                exp_mem[dst + k * 64 + j] = (j == org) ? 8'h00 : (j == tg[k]) ? pc : brd[j];
        exp_src = src; exp_dst = dst; exp_count = cnt; reads_seen = 0;
        slave_wr(4'd1, 32'(src));
        slave_wr(4'd2, {24'd0, pc});
        slave_wr(4'd3, 32'(dst));
    endtask

    task automatic run_case(input string name, input int src, input int dst,
                            input logic [7:0] pc, input int lit_cnt, input int lit_t[8],
                            input bit chk_stall);
        int cnt, stall, w0, bad;
        int tg[8];
        logic [31:0] rd;
        setup(src, dst, pc, cnt, tg);
        chk({name, "_model_cnt"}, 64'(cnt), 64'(lit_cnt));
        for (int k = 0; k < lit_cnt; k++) chk({name, "_model_tgt"}, 64'(tg[k]), 64'(lit_t[k]));
        slave_rd(4'd2, rd, stall);
        chk({name, "_piece_reg"}, 64'(rd), 64'(pc));
        w0 = writes_seen;
        slave_wr(4'd0, 32'd0);
        slave_rd(4'd0, rd, stall);
        chk({name, "_count"}, 64'(rd), 64'(lit_cnt));
        if (chk_stall) chk({name, "_stalled"}, 64'(stall > 0), 64'd1);
        chk({name, "_writes"}, 64'(writes_seen - w0), 64'(64 * lit_cnt));
        chk({name, "_reads"}, 64'(reads_seen), 64'd64);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== exp_mem[i]) bad++;
        chk({name, "_mem_bad_bytes"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int stall, n, cnt, w0;
        int tg[8];

        rst = 1'b1;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        for (int i = 0; i < 1024; i++) imem[i] = 8'h00;

        // Bus monitor: exclusivity and every accepted master transfer
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (master_read && master_write) begin
                        errors++; checks++;
                        $display("FAIL rw_exclusive: got read=1 write=1 expected one at most");
                    end
                    if (master_write && !master_waitrequest) begin
                        checks++;
                        if (master_address >= 1024 || int'(master_address) < exp_dst ||
                            int'(master_address) >= exp_dst + 64 * exp_count) begin
                            errors++;
                            $display("FAIL wr_addr: got %0d expected %0d..%0d", master_address,
                                     exp_dst, exp_dst + 64 * exp_count - 1);
                        end else if (master_writedata !==
                                     {{24{exp_mem[master_address[9:0]][7]}}, exp_mem[master_address[9:0]]}) begin
                            errors++;
                            $display("FAIL wr_data: addr %0d got %h expected %h", master_address,
                                     master_writedata, exp_mem[master_address[9:0]]);
                        end
                        writes_seen++;
                    end
                    if (master_read && !master_waitrequest) begin
                        chk("rd_addr", 64'(master_address), 64'(exp_src + reads_seen));
                        reads_seen++;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_slave_wait", 64'(slave_waitrequest), 64'd0);
        chk("rst_mread", 64'(master_read), 64'd0);
        chk("rst_mwrite", 64'(master_write), 64'd0);
        chk("rst_maddr", 64'(master_address), 64'd0);
        chk("rst_mwdata", 64'(master_writedata), 64'd0);
        chk("rst_sdata_idle", 64'(slave_readdata), 64'd0);
        slave_rd(4'd0, rd, stall);
        chk("rst_count", 64'(rd), 64'd0);
        chk("rst_done_nostall", 64'(stall), 64'd0);
        for (int a = 1; a < 4; a++) begin
            slave_rd(4'(a), rd, stall);
            chk("rst_reg", 64'(rd), 64'd0);
        end

        for (int i = 0; i < 64; i++) brd[i] = 8'h00;
        brd[1] = 8'd19;
        run_case("edge_knight", 0, 0, 8'd19, 3, '{18, 16, 11, 0, 0, 0, 0, 0}, 1'b0);

        brd[18] = 8'd1; brd[16] = 8'hFF;
        run_case("captures", 256, 0, 8'd19, 2, '{16, 11, 0, 0, 0, 0, 0, 0}, 1'b0);

        for (int i = 0; i < 64; i++) brd[i] = 8'h00;
        brd[1] = 8'd19;
        run_case("absent", 0, 64, 8'd29, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);

        brd[1] = 8'h00; brd[27] = 8'd19;
        run_case("center", 512, 128, 8'd19, 8, '{44, 42, 12, 10, 37, 33, 21, 17}, 1'b0);

        brd[27] = 8'hED; brd[44] = 8'd5; brd[42] = 8'hF0;
        run_case("black", 512, 0, 8'hED, 7, '{44, 12, 10, 37, 33, 21, 17, 0}, 1'b0);

        wait_n = 3; valid_dly = 2;
        brd[27] = 8'd19; brd[44] = 8'h00; brd[42] = 8'h00;
        run_case("center_slow", 512, 128, 8'd19, 8, '{44, 42, 12, 10, 37, 33, 21, 17}, 1'b1);
        for (int i = 0; i < 64; i++) brd[i] = 8'h00;
        brd[1] = 8'd19;
        run_case("edge_slow", 0, 0, 8'd19, 3, '{18, 16, 11, 0, 0, 0, 0, 0}, 1'b1);

        // Reset while emitting
        wait_n = 0; valid_dly = 0;
        brd[1] = 8'h00; brd[27] = 8'd19;
        setup(512, 0, 8'd19, cnt, tg);
        w0 = writes_seen;
        slave_wr(4'd0, 32'd0);
        n = 0;
        while (writes_seen < w0 + 10 && n < 5000) begin @(negedge clk); n++; end
        chk("emit_reached", 64'(n < 5000), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_mwrite", 64'(master_write), 64'd0);
        chk("arst_mread", 64'(master_read), 64'd0);
        chk("arst_maddr", 64'(master_address), 64'd0);
        repeat (3) @(negedge clk);
        chk("arst_hold_mwrite", 64'(master_write), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_mwrite", 64'(master_write || master_read), 64'd0);
        slave_rd(4'd0, rd, stall);
        chk("post_rst_count", 64'(rd), 64'd0);
        chk("post_rst_done", 64'(stall), 64'd0);
        slave_rd(4'd1, rd, stall);
        chk("post_rst_src", 64'(rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/knight_move_gen.md
Name: knight_move_gen

Overview:
- Hardware move generator for a knight piece on the chess accelerator's Avalon fabric.
- CPU programs the source board address, the piece code and the destination buffer address over an Avalon-MM slave, then starts generation.
- The block reads the 64-square board over an Avalon-MM master and writes one full 64-byte board per legal knight move, packed contiguously in the destination buffer.
- Reading slave register 0 stalls until generation finishes, then returns the number of boards written.

Parameters:
- None. Board is fixed at 64 squares of 8 bits, index = row*8 + col, row and col in 0..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- slave_waitrequest  out  1  slave stall
- slave_address  in  4  register select
- slave_read  in  1  slave read strobe
- slave_readdata  out  32  register read data
- slave_write  in  1  slave write strobe
- slave_writedata  in  32  register write data
- master_waitrequest  in  1  master stall from memory
- master_address  out  32  byte address, one square per transfer
- master_read  out  1  master read strobe
- master_readdata  in  32  read data; low 8 bits are the square code
- master_readdatavalid  in  1  read data valid
- master_write  out  1  master write strobe
- master_writedata  out  32  write data; square code sign-extended to 32 bits

Behaviour:
- Square codes are signed 8-bit: 0 = empty, >0 = white piece, <0 = black piece.
- Slave registers, all accepted on a clk edge when slave_waitrequest = 0:
  - 1 = SRC board base.
  - 2 = PIECE code, low 8 bits.
  - 3 = DST buffer base.
  - Write to 0 = START; clears DONE and COUNT, enters LOAD.
  - Read 0 returns COUNT, zero-extended.
  - Read 1/2/3 returns the register.
- slave_waitrequest is high when either:
  - state is not IDLE, or
  - slave_read = 1 with address 0 and DONE = 0.
- Writes during busy therefore stall.
- Reset values:
  - SRC = DST = PIECE = 0, COUNT = 0, DONE = 1, state IDLE.
  - All master strobes 0, master_address 0, master_writedata 0, slave_readdata 0.
- States and transitions:
  - IDLE to LOAD on START.
  - LOAD: 64 reads at SRC+0..SRC+63. Hold master_read and address until master_waitrequest = 0, then wait for master_readdatavalid. Capture the low byte into internal board[i]. One outstanding read at a time.
  - FIND: locate the lowest index where board[i] = PIECE. If not found, go to FINISH with COUNT = 0.
  - CANDIDATE: try (drow, dcol) offsets in this fixed order: (+2,+1), (+2,-1), (-2,+1), (-2,-1), (+1,+2), (+1,-2), (-1,+2), (-1,-2).
  - A target is legal when both:
    - row and col stay within 0..7 (no wrap across files), and
    - the target is empty or holds a piece whose sign is opposite to PIECE.
  - Illegal targets are skipped.
  - EMIT: for each legal target, write 64 squares to DST + COUNT*64 + 0..63. Board contents are the loaded board with origin = 0 and target = PIECE. Hold master_write and signals until master_waitrequest = 0. Then increment COUNT.
  - FINISH: set DONE = 1, return to IDLE.
- COUNT range is 0..8 and is 4 bits internally.
- The internal board is never modified; each output is derived from the original board.
- Reset mid-operation aborts immediately to reset values; no further master traffic.
- master_read and master_write are never high together.

Test Plan:
- Knight at index 1 on an otherwise empty board, PIECE = 19, SRC = 0, DST = 0 → COUNT = 3.
  - Boards at 0/64/128 have targets 18, 16, 11 in that order.
  - Origin 0 on each board; bytes beyond 191 untouched.
- Knight at index 1, square 18 holds own pawn (1), square 16 holds black pawn (-1) → COUNT = 2.
  - Targets 16 (captures), then 11.
- PIECE = 29 with no such piece on the board → COUNT = 0, no master writes, read of register 0 returns 0.
- Knight at index 27 (d4-equivalent), empty board → COUNT = 8, boards in offset order. Targets 44, 42, 12, 10, 37, 33, 21, 17.
- master_waitrequest held high 3 cycles per transfer and readdatavalid delayed 2 cycles → identical results.
  - Read of register 0 stalls until DONE.
- Assert rst during EMIT → all strobes 0 asynchronously. After release, DONE = 1 and COUNT = 0.
